// File: rtl/operand_entry.sv
// operand_entry -- sequential operand entry front end for the signed 4-bit
// add/sub display path.
//
// The user picks a sign on a switch and steps a magnitude with a pushbutton.
// A second pushbutton walks through operand A, operand B and DONE. The
// sign/magnitude entry is converted to two's complement for the adder.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   key_n    in   [1:0] raw pushbuttons, active-low; [0] increment, [1] advance
//   sign_sw  in   raw sign switch, 1 = negative
//   op_a     out  [3:0] operand A, two's complement
//   op_b     out  [3:0] operand B, two's complement
//   valid    out  both operands committed (state DONE)
//   field    out  [1:0] current state: 0 = A_EDIT, 1 = B_EDIT, 2 = DONE
//   cur_mag  out  [3:0] magnitude of the field being edited (0 in DONE)
//   cur_neg  out  sign of the field being edited (0 in DONE)
//
// Optional feature: define OPERAND_ENTRY_AUTO_REPEAT_EN to auto-repeat the
// increment key while it is held (first repeat REPEAT_DELAY cycles after the
// press, then every REPEAT_CYCLES; REPEAT_CYCLES must not exceed REPEAT_DELAY).

module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic       sign_sw,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       valid,
  output logic [1:0] field,
  output logic [3:0] cur_mag,
  output logic       cur_neg
);

  typedef enum logic [1:0] {
    A_EDIT = 2'd0,
    B_EDIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizers. Key stages reset to the "pressed" level so that a
  // key held through reset is never mistaken for a fresh press (see arm_q).
  logic [1:0] key_s1_q, key_s2_q;
  logic       sign_s1_q, sign_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q  <= 2'b00;
      key_s2_q  <= 2'b00;
      sign_s1_q <= 1'b0;
      sign_s2_q <= 1'b0;
    end else begin
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
      sign_s1_q <= sign_sw;
      sign_s2_q <= sign_s1_q;
    end
  end

  // Debouncers. press[k] is a one-cycle pulse on an accepted high-to-low
  // transition, only once the key has been seen released since reset.
  logic [1:0] press;
  logic [1:0] key_level;

  for (genvar k = 0; k < 2; k++) begin : g_db
    logic           stable_q;
    logic           arm_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_q <= 1'b1;
        arm_q    <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (key_s2_q[k]) arm_q <= 1'b1;
        if (key_s2_q[k] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          stable_q <= key_s2_q[k];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[k]     = stable_q & ~key_s2_q[k] & (cnt_q == DB_LAST) & arm_q;
    assign key_level[k] = stable_q;
  end

  logic adv;
  logic inc;
  assign adv = press[1];

`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  logic          hold_run_q;
  logic [HW-1:0] hold_q;
  logic          rep_pulse;

  // hold_q counts cycles since the accepted press; after a repeat it is
  // reloaded so the next repeat lands REPEAT_CYCLES later.
  assign rep_pulse = hold_run_q & (hold_q == HW'(REPEAT_DELAY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_run_q <= 1'b0;
      hold_q     <= '0;
    end else if (adv) begin
      hold_run_q <= 1'b0;
      hold_q     <= '0;
    end else if (press[0]) begin
      hold_run_q <= 1'b1;
      hold_q     <= HW'(1);
    end else if (key_level[0]) begin
      hold_run_q <= 1'b0;
      hold_q     <= '0;
    end else if (rep_pulse) begin
      hold_q <= HW'(REPEAT_DELAY - REPEAT_CYCLES + 1);
    end else if (hold_run_q) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  assign inc = press[0] | rep_pulse;
`else
  assign inc = press[0];
`endif

  // Next magnitude: wrap against the limit of the current sign, then clamp
  // 8 -> 7 if the sign being loaded this edge is positive.
  function automatic logic [3:0] next_mag(input logic [3:0] mag,
                                          input logic       neg_now,
                                          input logic       neg_new,
                                          input logic       step);
    logic [3:0] m;
    logic [3:0] mx;
    mx = neg_now ? 4'd8 : 4'd7;
    m  = mag;
    if (step) m = (mag >= mx) ? 4'd0 : mag + 4'd1;
    if (!neg_new && (m == 4'd8)) m = 4'd7;
    return m;
  endfunction

  function automatic logic [3:0] to_twos(input logic [3:0] mag, input logic neg);
    logic [4:0] t;
    t = ~{1'b0, mag} + 5'd1;
    return neg ? t[3:0] : mag;
  endfunction

  state_t     state_q;
  logic [3:0] mag_a_q, mag_b_q;
  logic       neg_a_q, neg_b_q;
  logic       step;

  // Advance wins over a coincident increment.
  assign step = inc & ~adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_EDIT;
      mag_a_q <= 4'd0;
      mag_b_q <= 4'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      case (state_q)
        A_EDIT: begin
          neg_a_q <= sign_s2_q;
          mag_a_q <= next_mag(mag_a_q, neg_a_q, sign_s2_q, step);
          if (adv) state_q <= B_EDIT;
        end
        B_EDIT: begin
          neg_b_q <= sign_s2_q;
          mag_b_q <= next_mag(mag_b_q, neg_b_q, sign_s2_q, step);
          if (adv) state_q <= DONE;
        end
        DONE: begin
          if (adv) begin
            state_q <= A_EDIT;
            mag_a_q <= 4'd0;
            mag_b_q <= 4'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
          end
        end
        default: state_q <= A_EDIT;
      endcase
    end
  end

  assign op_a    = to_twos(mag_a_q, neg_a_q);
  assign op_b    = to_twos(mag_b_q, neg_b_q);
  assign valid   = (state_q == DONE);
  assign field   = state_q;
  assign cur_mag = (state_q == A_EDIT) ? mag_a_q :
                   (state_q == B_EDIT) ? mag_b_q : 4'd0;
  assign cur_neg = (state_q == A_EDIT) ? neg_a_q :
                   (state_q == B_EDIT) ? neg_b_q : 1'b0;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RC = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic       sign_sw;
  logic [3:0] op_a, op_b, cur_mag;
  logic       valid, cur_neg;
  logic [1:0] field;

  always #5 clk = ~clk;

  operand_entry #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_n),
    .sign_sw(sign_sw),
    .op_a   (op_a),
    .op_b   (op_b),
    .valid  (valid),
    .field  (field),
    .cur_mag(cur_mag),
    .cur_neg(cur_neg)
  );

  // ---------------- reference model ----------------
  // State as 0/1/2, per-field magnitude and sign as plain integers.
  int n_cmp = 0;
  int n_err = 0;
  int m_state;
  int m_mag[2];
  int m_neg[2];
  int m_sign;

  function automatic int exp_op(int f);
    return m_neg[f] != 0 ? (16 - m_mag[f]) % 16 : m_mag[f];
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_mag[0] = 0; m_mag[1] = 0;
    m_neg[0] = m_sign; m_neg[1] = 0;
  endtask

  task automatic model_inc();
    int mx;
    if (m_state < 2) begin
      mx = (m_neg[m_state] != 0) ? 8 : 7;
      m_mag[m_state] = (m_mag[m_state] >= mx) ? 0 : m_mag[m_state] + 1;
    end
  endtask

  task automatic model_adv();
    if (m_state == 0) begin
      m_state  = 1;
      m_neg[1] = m_sign;
      if (m_sign == 0 && m_mag[1] == 8) m_mag[1] = 7;
    end else if (m_state == 1) begin
      m_state = 2;
    end else begin
      m_state  = 0;
      m_mag[0] = 0; m_mag[1] = 0;
      m_neg[1] = 0;
      m_neg[0] = m_sign;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".op_a"},    op_a,    exp_op(0));
    check({tag, ".op_b"},    op_b,    exp_op(1));
    check({tag, ".valid"},   valid,   (m_state == 2) ? 1 : 0);
    check({tag, ".field"},   field,   m_state);
    check({tag, ".cur_mag"}, cur_mag, (m_state < 2) ? m_mag[m_state] : 0);
    check({tag, ".cur_neg"}, cur_neg, (m_state < 2) ? m_neg[m_state] : 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    @(negedge clk);
    key_n[k] = 1'b0;
    idle(DB + 4);
    key_n[k] = 1'b1;
    idle(DB + 4);
    if (k == 0) model_inc();
    else        model_adv();
  endtask

  task automatic set_sign(input int v);
    @(negedge clk);
    sign_sw = v[0];
    m_sign  = v;
    if (m_state < 2) begin
      m_neg[m_state] = v;
      if (v == 0 && m_mag[m_state] == 8) m_mag[m_state] = 7;
    end
    idle(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_rep;
    int r;
    rst     = 1'b1;
    key_n   = 2'b11;
    sign_sw = 1'b0;
    m_sign  = 0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(6);
    check_all("reset");

    // Short glitch must not be accepted.
    key_n[0] = 1'b0;
    idle(2);
    key_n[0] = 1'b1;
    idle(DB + 6);
    check("glitch_mag", cur_mag, 0);

    // Positive wrap: 1..7,0,1.
    for (int i = 0; i < 9; i++) begin
      press(0);
      check("pos_seq", cur_mag, (i < 7) ? i + 1 : i - 7);
      check_all("pos_seq");
    end

    // Negative: reach 8, -8 encodes as 1000.
    set_sign(1);
    for (int i = 0; i < 7; i++) press(0);
    check("neg8_mag", cur_mag, 8);
    check("neg8_op", op_a, 8'h08);

    // Sign drops while at 8: clamp to 7 within sync latency + 1.
    set_sign(0);
    check("clamp_op", op_a, 8'h07);
    check_all("clamp");

    // A = -3, B = +5.
    set_sign(1);
    for (int i = 0; i < 10 && m_mag[0] != 3; i++) press(0);
    check("a_minus3", op_a, 8'h0D);
    press(1);
    set_sign(0);
    for (int i = 0; i < 10 && m_mag[1] != 5; i++) press(0);
    check("b_plus5", op_b, 8'h05);
    press(1);
    check("done_valid", valid, 1);
    check("done_field", field, 2);
    check("done_opa", op_a, 8'h0D);
    press(0);
    press(0);
    set_sign(1);
    check_all("done_ignore");
    press(1);
    check_all("done_exit");
    check("exit_opa", op_a, 0);
    check("exit_opb", op_b, 0);
    set_sign(0);

    // Simultaneous increment and advance: advance wins.
    press(0);
    @(negedge clk);
    key_n = 2'b00;
    idle(DB + 4);
    key_n = 2'b11;
    idle(DB + 4);
    model_adv();
    check("simul_field", field, 1);
    check("simul_opa", op_a, 1);
    check_all("simul");
    press(1);
    press(1);
    check_all("back_to_a");

    // Reset while the increment key is mid-debounce and held through release.
    @(negedge clk);
    key_n[0] = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    idle(20);
    check("hold_thru_rst", cur_mag, 0);
    key_n[0] = 1'b1;
    idle(DB + 6);
    check_all("after_rst_release");
    press(0);
    check_all("after_rst_press");

    // Long hold: press accepted ~6 cycles in, release accepted 40 cycles later.
    @(negedge clk);
    key_n[0] = 1'b0;
    idle(40);
    key_n[0] = 1'b1;
    idle(DB + 6);
`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
    n_rep = 4;
`else
    n_rep = 1;
`endif
    for (int i = 0; i < n_rep; i++) model_inc();
    check("hold_count", cur_mag, m_mag[0]);
    check_all("hold");

    // Randomized operations against the model.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      press(0);
      else if (r <= 7) press(1);
      else             set_sign($urandom_range(0, 1));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
